inst_fetch_responder: RTL and testbench

//  Memory-side responder for the IF stage's instruction fetch interface. Takes IF's combinational

---
 rtl/inst_fetch_responder_pkg.sv | 17 +
 rtl/icache_array.sv | 58 +++++
 rtl/inst_fetch_responder.sv | 115 +++++++++++
 tb/tb_inst_fetch_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder and its cache array.
package inst_fetch_responder_pkg;

  localparam int IFR_IDX_W  = 6;
  localparam int IFR_ADDR_W = 32;
  localparam int IFR_RAM_AW = 17;
  localparam int INST_W     = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IFR_IDLE = 2'd0,
    IFR_REQ  = 2'd1,
    IFR_DONE = 2'd2
  } ifr_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage: valid bits, tags and data,
// one synchronous write port, one asynchronous read port and a flush-all.
module icache_array
  import inst_fetch_responder_pkg::*;
#(
  parameter int IDX_W = IFR_IDX_W,
  parameter int TAG_W = IFR_ADDR_W - IFR_IDX_W - 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              we_in,
  input  logic [IDX_W-1:0]  w_idx_in,
  input  logic [TAG_W-1:0]  w_tag_in,
  input  logic [INST_W-1:0] w_data_in,
  input  logic [IDX_W-1:0]  r_idx_in,
  output logic              r_valid_out,
  output logic [TAG_W-1:0]  r_tag_out,
  output logic [INST_W-1:0] r_data_out
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  // Flush beats a same-cycle fill so a fence.i never leaves a stale line behind.
  always_comb begin
    valid_d = valid_q;
    if (flush_in) begin
      valid_d = '0;
    end else if (we_in) begin
      valid_d[w_idx_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; valid_q alone decides whether a line is live.
  always_ff @(posedge clk_in) begin
    if (we_in) begin
      tag_mem[w_idx_in]  <= w_tag_in;
      data_mem[w_idx_in] <= w_data_in;
    end
  end

  assign r_valid_out = valid_q[r_idx_in];
  assign r_tag_out   = tag_mem[r_idx_in];
  assign r_data_out  = data_mem[r_idx_in];

endmodule

// File: rtl/inst_fetch_responder.sv
// IF-side instruction responder: zero-latency hits from a direct-mapped cache, misses stall IF
// while the word is fetched byte by byte over the shared RAM bus and written into the cache.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int IDX_W  = IFR_IDX_W,
  parameter int ADDR_W = IFR_ADDR_W,
  parameter int RAM_AW = IFR_RAM_AW
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [INST_W-1:0] data_out,
  output logic              blk_out,
  input  logic              flush_in,
  input  logic              ram_gnt_in,
  output logic [RAM_AW-1:0] ram_a_out,
  output logic              ram_rd_out,
  input  logic [7:0]        ram_d_in
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  ifr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] miss_a_q, miss_a_d;
  logic [2:0]        k_q, k_d;
  logic [3:0]        pend_q, pend_d;
  logic [INST_W-1:0] byte_buf_q, byte_buf_d;

  logic [ADDR_W-1:0] addr_w;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [INST_W-1:0] line_data;
  logic              hit, abort, fill_we;

  assign addr_w = addr_in & ~ADDR_W'(3);

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_icache_array (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .we_in       (fill_we),
    .w_idx_in    (miss_a_q[IDX_W+1:2]),
    .w_tag_in    (miss_a_q[ADDR_W-1:IDX_W+2]),
    .w_data_in   (byte_buf_d),
    .r_idx_in    (addr_w[IDX_W+1:2]),
    .r_valid_out (line_valid),
    .r_tag_out   (line_tag),
    .r_data_out  (line_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IFR_IDLE;
      miss_a_q   <= '0;
      k_q        <= '0;
      pend_q     <= '0;
      byte_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_a_q   <= miss_a_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      byte_buf_q <= byte_buf_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    miss_a_d   = miss_a_q;
    k_d        = k_q;
    pend_d     = '0;
    byte_buf_d = byte_buf_q;
    for (int i = 0; i < 4; i++) begin
      if (pend_q[i]) byte_buf_d[8*i +: 8] = ram_d_in;
    end
    unique case (state_q)
      IFR_IDLE: begin
        if (!hit) begin
          state_d  = IFR_REQ;
          miss_a_d = addr_w;
          k_d      = '0;
        end
      end
      IFR_REQ: begin
        if (abort) begin
          state_d = IFR_IDLE;
        end else if (ram_gnt_in) begin
          pend_d[k_q[1:0]] = 1'b1;
          k_d              = k_q + 3'd1;
          // The last byte arrives while in DONE and goes straight into the line.
          if (k_q == 3'd3) state_d = IFR_DONE;
        end
      end
      IFR_DONE: state_d = IFR_IDLE;
      default:  state_d = IFR_IDLE;
    endcase
  end

  always_comb begin
    hit        = !rst_in && line_valid && (line_tag == addr_w[ADDR_W-1:IDX_W+2])
                 && (state_q == IFR_IDLE);
    abort      = (state_q != IFR_IDLE) && (addr_w != miss_a_q);
    fill_we    = (state_q == IFR_DONE) && !abort && !rst_in;
    blk_out    = !hit;
    data_out   = hit ? line_data : ZERO_WORD;
    ram_rd_out = (state_q == IFR_REQ) && ram_gnt_in && !abort && !rst_in;
    ram_a_out  = ram_rd_out ? (miss_a_q[RAM_AW-1:0] + RAM_AW'(k_q)) : '0;
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: fills, hits, RAM stalls, redirects, aliasing, flush.
module tb_inst_fetch_responder;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, ram_gnt_in;
  logic [31:0] addr_in, data_out;
  logic        blk_out, ram_rd_out;
  logic [16:0] ram_a_out;
  logic [7:0]  ram_d_in;

  logic [7:0]  ram_mem [0:511];
  logic [16:0] seen_a  [0:15];
  int          n_seen;
  int          total = 0;
  int          bad   = 0;

  always #5 clk_in = ~clk_in;

  inst_fetch_responder dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .addr_in    (addr_in),
    .data_out   (data_out),
    .blk_out    (blk_out),
    .flush_in   (flush_in),
    .ram_gnt_in (ram_gnt_in),
    .ram_a_out  (ram_a_out),
    .ram_rd_out (ram_rd_out),
    .ram_d_in   (ram_d_in)
  );

  // Byte-wide RAM: data for a read strobe appears on the following cycle.
  always @(posedge clk_in) ram_d_in <= ram_rd_out ? ram_mem[ram_a_out[8:0]] : 8'h00;

  task automatic next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present address a until blk_out drops; gnt_low bit c holds the grant low in stall cycle c.
  task automatic fill(input logic [31:0] a, input logic [31:0] gnt_low,
                      output int stalls, output logic [31:0] word);
    stalls  = -1;
    word    = 'x;
    n_seen  = 0;
    addr_in = a;
    for (int c = 0; c < 40; c++) begin
      ram_gnt_in = (c < 32) ? ~gnt_low[c] : 1'b1;
      @(negedge clk_in);
      if (!blk_out) begin
        stalls = c;
        word   = data_out;
        break;
      end
      if (ram_rd_out && n_seen < 16) begin
        seen_a[n_seen] = ram_a_out;
        n_seen++;
      end
      next();
    end
    ram_gnt_in = 1'b1;
  endtask

  task automatic check_fill(input string tag, input logic [31:0] a, input logic [31:0] gnt_low,
                            input int exp_stalls, input logic [31:0] exp_word);
    int          stalls;
    logic [31:0] word;
    fill(a, gnt_low, stalls, word);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_word"}, word, exp_word);
    check({tag, "_nrd"}, 32'(n_seen >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_addr"}, (n_seen >= 4) ? {15'd0, seen_a[n_seen-4+i]} : 'x,
            (a + 32'(i)) & 32'h1ffff);
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    flush_in   = 1'b0;
    ram_gnt_in = 1'b1;
    addr_in    = 32'h0;
    for (int i = 0; i < 512; i++) ram_mem[i] = 8'h00;
    ram_mem[9'h000] = 8'h13;
    ram_mem[9'h004] = 8'h01; ram_mem[9'h005] = 8'h02; ram_mem[9'h006] = 8'h03; ram_mem[9'h007] = 8'h04;
    ram_mem[9'h040] = 8'h78; ram_mem[9'h041] = 8'h56; ram_mem[9'h042] = 8'h34; ram_mem[9'h043] = 8'h12;
    ram_mem[9'h080] = 8'haa; ram_mem[9'h081] = 8'hbb; ram_mem[9'h082] = 8'hcc; ram_mem[9'h083] = 8'hdd;
    ram_mem[9'h100] = 8'h11; ram_mem[9'h101] = 8'h22; ram_mem[9'h102] = 8'h33; ram_mem[9'h103] = 8'h44;

    // Reset state
    next();
    next();
    @(negedge clk_in);
    check("rst_blk", blk_out, 1);
    check("rst_data", data_out, 0);
    check("rst_rd", ram_rd_out, 0);
    check("rst_a", ram_a_out, 0);

    // 1: cold miss at 0 -> six stall cycles, bytes 0..3
    next();
    rst_in = 1'b0;
    check_fill("t1", 32'h0, 32'h0, 6, 32'h00000013);

    // 2: same address hits with no RAM traffic
    next();
    addr_in = 32'h0;
    @(negedge clk_in);
    check("t2_blk", blk_out, 0);
    check("t2_data", data_out, 32'h00000013);
    check("t2_rd", ram_rd_out, 0);

    // 3: grant withheld for three cycles mid-fetch stretches the stall by three
    next();
    check_fill("t3", 32'h40, 32'h38, 9, 32'h12345678);

    // 4: redirect from 0x80 to 0x100 after two reads
    next();
    addr_in = 32'h80;
    @(negedge clk_in);
    check("t4_miss", blk_out, 1);
    next();
    @(negedge clk_in);
    check("t4_rd0", ram_rd_out, 1);
    check("t4_a0", ram_a_out, 32'h80);
    next();
    @(negedge clk_in);
    check("t4_a1", ram_a_out, 32'h81);
    next();
    check_fill("t4_new", 32'h100, 32'h0, 7, 32'h44332211);
    next();
    check_fill("t4_old", 32'h80, 32'h0, 6, 32'hddccbbaa);

    // 5: 0x0 and 0x100 share index 0 and evict each other
    next();
    check_fill("t5_a", 32'h0, 32'h0, 6, 32'h00000013);
    next();
    check_fill("t5_b", 32'h100, 32'h0, 6, 32'h44332211);
    next();
    check_fill("t5_c", 32'h0, 32'h0, 6, 32'h00000013);

    // 6: flush during DONE of 0x4 suppresses the write
    next();
    addr_in = 32'h4;
    repeat (5) next();
    flush_in = 1'b1;
    @(negedge clk_in);
    check("t6_done_blk", blk_out, 1);
    next();
    flush_in = 1'b0;
    check_fill("t6_refill", 32'h4, 32'h0, 6, 32'h04030201);
    next();
    addr_in = 32'h0;
    @(negedge clk_in);
    check("t6_other_flushed", blk_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
